dmem_ctrl: RTL and testbench

- Arbitrates two load/store requesters over the single-port word-addressed data memory.
  - m0: the pipeline MEM stage.
  - m1: debug/DMA loader.
- Translates RV32I byte/half/word accesses into the memory's word address, byte-lane enables and lane-replicated write data.
- Aligns and sign-/zero-extends load data on return.
- Sits between the MEM stage / debug port and the data memory. Sequences the memory's one-cycle registered read.

---
 rtl/dmem_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: arbitrates two load/store requesters (m0 = MEM stage, m1 = debug/DMA loader)
// onto a single-port, word-addressed data memory with a one-cycle registered read.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   mN_req_valid/ready    - request handshake (N = 0,1); ready is combinational in IDLE
//   mN_we, mN_funct3      - store flag and RV32I width code
//   mN_addr, mN_wdata     - byte address and right-justified store data
//   mN_rsp_valid          - one-cycle response pulse, no backpressure
//   mN_rsp_rdata          - extended load data (0 for stores and errors)
//   mN_rsp_err            - misaligned / illegal funct3 / out-of-range
//   mem_we, mem_byteEnable, mem_address, mem_wd - memory write/read command
//   mem_rd                - memory read data, valid the cycle after a read
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter bit          RR_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_we,
  input  logic [2:0]  m0_funct3,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_rsp_valid,
  output logic [31:0] m0_rsp_rdata,
  output logic        m0_rsp_err,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_we,
  input  logic [2:0]  m1_funct3,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_rsp_valid,
  output logic [31:0] m1_rsp_rdata,
  output logic        m1_rsp_err,
  output logic        mem_we,
  output logic [3:0]  mem_byteEnable,
  output logic [29:0] mem_address,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;      // requester granted most recently (1 = m1)
  logic        rd_id_q, rd_id_d;
  logic [2:0]  rd_f3_q, rd_f3_d;
  logic [1:0]  rd_off_q, rd_off_d;
  logic [1:0]  rsp_v_q, rsp_v_d;    // store/error response pulse, one bit per requester
  logic        rsp_err_q, rsp_err_d;

  logic        gnt0, gnt1, gnt_any;
  logic        s_we, s_err;
  logic [2:0]  s_f3;
  logic [31:0] s_addr, s_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        rd_rsp;

  // Arbitration; nothing is granted while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle && !reset) begin
      if (m0_req_valid && m1_req_valid) begin
        if (RR_EN) begin
          gnt1 = !last_q;
          gnt0 = last_q;
        end else begin
          gnt0 = 1'b1;
        end
      end else begin
        gnt0 = m0_req_valid;
        gnt1 = m1_req_valid;
      end
    end
    gnt_any = gnt0 | gnt1;
  end

  // Selected request and its legality.
  always_comb begin
    s_we    = gnt1 ? m1_we     : m0_we;
    s_f3    = gnt1 ? m1_funct3 : m0_funct3;
    s_addr  = gnt1 ? m1_addr   : m0_addr;
    s_wdata = gnt1 ? m1_wdata  : m0_wdata;
    unique case (s_f3)
      3'b000, 3'b100: s_err = 1'b0;
      3'b001, 3'b101: s_err = s_addr[0];
      3'b010:         s_err = (s_addr[1:0] != 2'b00);
      default:        s_err = 1'b1;
    endcase
    if ({2'b00, s_addr[31:2]} >= DEPTH_WORDS) s_err = 1'b1;
  end

  // Memory command and next state.
  always_comb begin
    mem_we         = 1'b0;
    mem_byteEnable = 4'b0000;
    mem_address    = 30'd0;
    mem_wd         = 32'd0;
    state_d        = state_q;
    last_d         = last_q;
    rd_id_d        = rd_id_q;
    rd_f3_d        = rd_f3_q;
    rd_off_d       = rd_off_q;
    rsp_v_d        = 2'b00;
    rsp_err_d      = 1'b0;

    if (gnt_any) begin
      last_d = gnt1;
      if (s_err) begin
        rsp_v_d   = {gnt1, gnt0};
        rsp_err_d = 1'b1;
      end else if (s_we) begin
        mem_we      = 1'b1;
        mem_address = s_addr[31:2];
        rsp_v_d     = {gnt1, gnt0};
        unique case (s_f3[1:0])
          2'b00: begin
            mem_byteEnable = 4'b0001 << s_addr[1:0];
            mem_wd         = {4{s_wdata[7:0]}};
          end
          2'b01: begin
            mem_byteEnable = s_addr[1] ? 4'b1100 : 4'b0011;
            mem_wd         = {2{s_wdata[15:0]}};
          end
          default: begin
            mem_byteEnable = 4'b1111;
            mem_wd         = s_wdata;
          end
        endcase
      end else begin
        mem_address = s_addr[31:2];
        state_d     = StRdWait;
        rd_id_d     = gnt1;
        rd_f3_d     = s_f3;
        rd_off_d    = s_addr[1:0];
      end
    end

    if (state_q == StRdWait) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      rd_id_q   <= 1'b0;
      rd_f3_q   <= 3'b000;
      rd_off_q  <= 2'b00;
      rsp_v_q   <= 2'b00;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      rd_id_q   <= rd_id_d;
      rd_f3_q   <= rd_f3_d;
      rd_off_q  <= rd_off_d;
      rsp_v_q   <= rsp_v_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Load data alignment and extension from the registered read.
  always_comb begin
    ld_byte = 8'(mem_rd >> {rd_off_q, 3'b000});
    ld_half = rd_off_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    unique case (rd_f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rd;
    endcase
  end

  // Outputs are forced low during reset so a pending read never responds.
  always_comb begin
    rd_rsp       = (state_q == StRdWait) && !reset;
    m0_req_ready = gnt0;
    m1_req_ready = gnt1;
    m0_rsp_valid = !reset && (rsp_v_q[0] || (rd_rsp && !rd_id_q));
    m1_rsp_valid = !reset && (rsp_v_q[1] || (rd_rsp && rd_id_q));
    m0_rsp_err   = !reset && rsp_v_q[0] && rsp_err_q;
    m1_rsp_err   = !reset && rsp_v_q[1] && rsp_err_q;
    m0_rsp_rdata = (rd_rsp && !rd_id_q) ? ld_data : 32'd0;
    m1_rsp_rdata = (rd_rsp && rd_id_q) ? ld_data : 32'd0;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  logic        clk, reset;
  logic        m0_req_valid, m0_req_ready, m0_we, m0_rsp_valid, m0_rsp_err;
  logic [2:0]  m0_funct3;
  logic [31:0] m0_addr, m0_wdata, m0_rsp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_we, m1_rsp_valid, m1_rsp_err;
  logic [2:0]  m1_funct3;
  logic [31:0] m1_addr, m1_wdata, m1_rsp_rdata;
  logic        mem_we;
  logic [3:0]  mem_byteEnable;
  logic [29:0] mem_address;
  logic [31:0] mem_wd, mem_rd;

  // Fixed-priority instance sharing the request inputs.
  logic        fp_m0_ready, fp_m1_ready, fp_m0_rv, fp_m1_rv, fp_m0_err, fp_m1_err, fp_we;
  logic [31:0] fp_m0_rd, fp_m1_rd, fp_wd, fp_mem_rd;
  logic [3:0]  fp_be;
  logic [29:0] fp_addr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] sb_q0[$];
  logic [32:0] sb_q1[$];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] phys [0:255];

  logic        t_we;
  logic [3:0]  t_be;
  logic [29:0] t_addr;
  logic [31:0] t_wd;

  dmem_ctrl #(.DEPTH_WORDS(256), .RR_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_we(m0_we),
    .m0_funct3(m0_funct3), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_we(m1_we),
    .m1_funct3(m1_funct3), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .mem_we(mem_we), .mem_byteEnable(mem_byteEnable), .mem_address(mem_address),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  dmem_ctrl #(.DEPTH_WORDS(256), .RR_EN(1'b0)) u_dut_fp (
    .clk(clk), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(fp_m0_ready), .m0_we(m0_we),
    .m0_funct3(m0_funct3), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rsp_valid(fp_m0_rv), .m0_rsp_rdata(fp_m0_rd), .m0_rsp_err(fp_m0_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(fp_m1_ready), .m1_we(m1_we),
    .m1_funct3(m1_funct3), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rsp_valid(fp_m1_rv), .m1_rsp_rdata(fp_m1_rd), .m1_rsp_err(fp_m1_err),
    .mem_we(fp_we), .mem_byteEnable(fp_be), .mem_address(fp_addr),
    .mem_wd(fp_wd), .mem_rd(fp_mem_rd)
  );

  assign fp_mem_rd = 32'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "time limit");
  end

  // Memory: byte-lane writes, one-cycle registered read.
  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_byteEnable[i]) phys[mem_address[7:0]][8*i +: 8] <= mem_wd[8*i +: 8];
    end
    mem_rd <= phys[mem_address[7:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {err, rdata}; stores update the byte-array image.
  function automatic logic [32:0] model(input bit we, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] wd);
    bit          err;
    logic [9:0]  b;
    logic [15:0] h;
    case (f3)
      3'b000, 3'b100: err = 1'b0;
      3'b001, 3'b101: err = a[0];
      3'b010:         err = (a[1:0] != 2'b00);
      default:        err = 1'b1;
    endcase
    if (a[31:2] >= 30'd256) err = 1'b1;
    if (err) return {1'b1, 32'd0};
    b = a[9:0];
    if (we) begin
      ref_mem[b] = wd[7:0];
      if (f3[1:0] != 2'b00) ref_mem[b + 10'd1] = wd[15:8];
      if (f3[1:0] == 2'b10) begin
        ref_mem[b + 10'd2] = wd[23:16];
        ref_mem[b + 10'd3] = wd[31:24];
      end
      return 33'd0;
    end
    h = {ref_mem[b + 10'd1], ref_mem[b]};
    case (f3)
      3'b000:  return {1'b0, {24{ref_mem[b][7]}}, ref_mem[b]};
      3'b100:  return {1'b0, 24'd0, ref_mem[b]};
      3'b001:  return {1'b0, {16{h[15]}}, h};
      3'b101:  return {1'b0, 16'd0, h};
      default: return {1'b0, ref_mem[b + 10'd3], ref_mem[b + 10'd2], h};
    endcase
  endfunction

  task automatic drive(input int p, input bit v, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      m0_req_valid = v; m0_we = we; m0_funct3 = f3; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_req_valid = v; m1_we = we; m1_funct3 = f3; m1_addr = a; m1_wdata = wd;
    end
  endtask

  task automatic push(input int p, input logic [32:0] e);
    if (p == 0) sb_q0.push_back(e);
    else        sb_q1.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after acceptance with the memory
  // command of the grant cycle captured in t_*.
  task automatic do_req(input int p, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    bit done = 1'b0;
    drive(p, 1'b1, we, f3, a, wd);
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if ((p == 0) ? m0_req_ready : m1_req_ready) begin
        t_we = mem_we; t_be = mem_byteEnable; t_addr = mem_address; t_wd = mem_wd;
        push(p, model(we, f3, a, wd));
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) check_eq("grant_timeout", 32'd0, 32'd1);
    drive(p, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Response scoreboard.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset) begin
      if (m0_rsp_valid && m1_rsp_valid) check_eq("one_rsp_per_cycle", 32'd2, 32'd1);
      if (m0_rsp_valid) begin
        if (sb_q0.size() == 0) check_eq("rsp0_unexpected", 32'd1, 32'd0);
        else begin
          e = sb_q0.pop_front();
          check_eq("rsp0_rdata", m0_rsp_rdata, e[31:0]);
          check_eq("rsp0_err", {31'd0, m0_rsp_err}, {31'd0, e[32]});
        end
      end
      if (m1_rsp_valid) begin
        if (sb_q1.size() == 0) check_eq("rsp1_unexpected", 32'd1, 32'd0);
        else begin
          e = sb_q1.pop_front();
          check_eq("rsp1_rdata", m1_rsp_rdata, e[31:0]);
          check_eq("rsp1_err", {31'd0, m1_rsp_err}, {31'd0, e[32]});
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    idle_cycles(2);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) phys[i] = 32'd0;
    drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    do_reset();
    #1;
    check_eq("rst_outputs", {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid,
                             mem_we, mem_byteEnable}, 32'd0);
    check_eq("rst_mem_addr_wd", {2'b00, mem_address} | mem_wd, 32'd0);
    @(negedge clk);

    // Store word then load word.
    do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check_eq("sw_cmd", {27'd0, t_we, t_be}, {27'd0, 1'b1, 4'b1111});
    check_eq("sw_addr", {2'b00, t_addr}, 32'd4);
    check_eq("sw_wd", t_wd, 32'hDEADBEEF);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'd0);
    check_eq("lw_cmd", {27'd0, t_we, t_be}, 32'd0);
    check_eq("lw_addr", {2'b00, t_addr}, 32'd4);
    idle_cycles(1);

    // Sub-word stores and loads.
    do_req(0, 1'b1, 3'b000, 32'h13, 32'h00000080);
    check_eq("sb_be", {28'd0, t_be}, 32'h8);
    check_eq("sb_wd", t_wd, 32'h80808080);
    do_req(0, 1'b0, 3'b000, 32'h13, 32'd0);
    do_req(1, 1'b0, 3'b100, 32'h13, 32'd0);
    do_req(0, 1'b1, 3'b001, 32'h12, 32'h00008001);
    check_eq("sh_be", {28'd0, t_be}, 32'hC);
    check_eq("sh_wd", t_wd, 32'h80018001);
    do_req(0, 1'b0, 3'b001, 32'h12, 32'd0);
    do_req(1, 1'b0, 3'b101, 32'h12, 32'd0);
    do_req(1, 1'b0, 3'b000, 32'h11, 32'd0);
    idle_cycles(1);

    // Error cases: memory never written.
    do_req(0, 1'b0, 3'b010, 32'h11, 32'd0);
    check_eq("err_lw_mis_we", {31'd0, t_we}, 32'd0);
    do_req(0, 1'b1, 3'b001, 32'h15, 32'h1234);
    check_eq("err_sh_mis_we", {31'd0, t_we}, 32'd0);
    do_req(1, 1'b1, 3'b011, 32'h10, 32'h55);
    check_eq("err_f3_we", {31'd0, t_we}, 32'd0);
    do_req(0, 1'b1, 3'b010, 32'h400, 32'hCAFE0000);
    check_eq("err_range_we", {31'd0, t_we}, 32'd0);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'd0);
    idle_cycles(2);

    // Contention from reset: RR alternates m0,m1; fixed priority always m0.
    do_reset();
    drive(0, 1'b1, 1'b1, 3'b010, 32'h20, 32'hA0A0A0A0);
    drive(1, 1'b1, 1'b1, 3'b010, 32'h24, 32'hB1B1B1B1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("rr_m0_ready", {31'd0, m0_req_ready}, {31'd0, ~i[0]});
      check_eq("rr_m1_ready", {31'd0, m1_req_ready}, {31'd0, i[0]});
      check_eq("fp_ready", {30'd0, fp_m0_ready, fp_m1_ready}, 32'd2);
      if (m0_req_ready) push(0, model(1'b1, 3'b010, 32'h20, 32'hA0A0A0A0));
      if (m1_req_ready) push(1, model(1'b1, 3'b010, 32'h24, 32'hB1B1B1B1));
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    idle_cycles(1);

    // Load occupancy: m1 load wins (m0 granted last), m0 store waits until T+2.
    do_req(0, 1'b1, 3'b010, 32'h30, 32'h11112222);
    drive(1, 1'b1, 1'b0, 3'b010, 32'h30, 32'd0);
    drive(0, 1'b1, 1'b1, 3'b010, 32'h34, 32'h33334444);
    #1;
    check_eq("occ_t_ready", {30'd0, m0_req_ready, m1_req_ready}, 32'd1);
    if (m1_req_ready) push(1, model(1'b0, 3'b010, 32'h30, 32'd0));
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    check_eq("occ_t1_ready", {30'd0, m0_req_ready, m1_req_ready}, 32'd0);
    check_eq("occ_t1_rsp", {30'd0, m0_rsp_valid, m1_rsp_valid}, 32'd1);
    @(negedge clk);
    #1;
    check_eq("occ_t2_ready", {31'd0, m0_req_ready}, 32'd1);
    check_eq("occ_t2_rsp", {30'd0, m0_rsp_valid, m1_rsp_valid}, 32'd0);
    if (m0_req_ready) push(0, model(1'b1, 3'b010, 32'h34, 32'h33334444));
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    idle_cycles(2);

    // Reset during RD_WAIT drops the read.
    drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
    #1;
    check_eq("rdw_grant", {31'd0, m0_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    check_eq("rdw_rst_outputs", {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid,
                                 mem_we, mem_byteEnable}, 32'd0);
    check_eq("rdw_rst_rdata", m0_rsp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_rst_rsp", {30'd0, m0_rsp_valid, m1_rsp_valid}, 32'd0);
    @(negedge clk);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'd0);
    idle_cycles(3);

    check_eq("sb0_empty", sb_q0.size(), 32'd0);
    check_eq("sb1_empty", sb_q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
